// File: rtl/pixel_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_write_buffer
// Description : Converts the plotter's (x, y, colour) pixel stream into linear
//               framebuffer addresses, queues them in a small FIFO and drains
//               the FIFO into the framebuffer write port whenever memory
//               grants access.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_write_buffer #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int ADDR_W          = 15,
    parameter int DEPTH           = 16,
    parameter int CNT_W           = 5
) (
    input  logic              iClock,
    input  logic              iResetn,
    input  logic [7:0]        iX,
    input  logic [6:0]        iY,
    input  logic [2:0]        iColour,
    input  logic              iPlot,
    input  logic              iMemReady,
    input  logic              iClearOvf,
    output logic [ADDR_W-1:0] oAddr,
    output logic [2:0]        oData,
    output logic              oWrEn,
    output logic              oEmpty,
    output logic              oFull,
    output logic [CNT_W-1:0]  oCount,
    output logic              oOverflow,
    output logic              oRangeErr
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               ENTRY_W = ADDR_W + 3;
    localparam logic [8:0]       c_X_LIM = 9'(X_SCREEN_PIXELS);
    localparam logic [7:0]       c_Y_LIM = 8'(Y_SCREEN_PIXELS);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    // Stage 1 registers
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [2:0]        r_s1_colour;
    logic              r_range_err;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;

    // Output registers
    logic [ADDR_W-1:0] r_out_addr;
    logic [2:0]        r_out_data;
    logic              r_wr_en;
    logic              r_overflow;

    logic               w_in_range;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count_next;

    assign w_in_range = ({1'b0, iX} < c_X_LIM) && ({1'b0, iY} < c_Y_LIM);
    assign w_addr     = ADDR_W'(iY) * ADDR_W'(X_SCREEN_PIXELS) + ADDR_W'(iX);

    // A pop never happens at empty, so there is no same-cycle bypass path.
    assign w_pop  = (r_count != '0) && iMemReady;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = r_s1_valid && ((r_count != c_DEPTH) || w_pop);
    assign w_drop = r_s1_valid && !w_push;
    assign w_head = r_mem[r_rd_ptr];

    // Next occupancy, used so full/empty flags register alongside the count
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Stage 1: range check and linear address computation
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_colour <= '0;
            r_range_err <= 1'b0;
        end else begin
            r_s1_valid  <= iPlot && w_in_range;
            r_range_err <= iPlot && !w_in_range;
            if (iPlot && w_in_range) begin
                r_s1_addr   <= w_addr;
                r_s1_colour <= iColour;
            end
        end
    end

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge iClock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_s1_addr, r_s1_colour};
        end
    end

    // FIFO pointers, occupancy and flags; pointers wrap naturally at DEPTH
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH);
            r_empty <= (w_count_next == '0);
        end
    end

    // Output register and sticky overflow; a drop beats a same-cycle clear
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_out_addr <= '0;
            r_out_data <= '0;
            r_wr_en    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_out_addr <= w_head[ENTRY_W-1:3];
                r_out_data <= w_head[2:0];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (iClearOvf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign oAddr     = r_out_addr;
    assign oData     = r_out_data;
    assign oWrEn     = r_wr_en;
    assign oEmpty    = r_empty;
    assign oFull     = r_full;
    assign oCount    = r_count;
    assign oOverflow = r_overflow;
    assign oRangeErr = r_range_err;

endmodule
`default_nettype wire

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
Downstream stage of the box/clear plotter. It takes the plotter's pixel stream (x, y, colour, plot strobe) and converts each pixel to a linear framebuffer address. Pixels are queued in a small FIFO. The FIFO drains into the VGA adapter's framebuffer write port only while the memory side grants access, so the plotter never stalls on memory arbitration.

Parameters:
X_SCREEN_PIXELS, 160, visible width; valid x range is 0..X_SCREEN_PIXELS-1
Y_SCREEN_PIXELS, 120, visible height; valid y range is 0..Y_SCREEN_PIXELS-1
ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= X*Y (19200 at default)
DEPTH, 16, FIFO entries; power of two
CNT_W, 5, occupancy counter width, equal to log2(DEPTH)+1

Ports:
iClock  in  1  system clock; all state updates on the rising edge
iResetn  in  1  reset, asynchronous assert, active-low
iX  in  8  pixel x coordinate from the plotter
iY  in  7  pixel y coordinate from the plotter
iColour  in  3  pixel colour
iPlot  in  1  pixel valid strobe; one pixel per cycle while high
iMemReady  in  1  framebuffer write port available this cycle
iClearOvf  in  1  synchronous clear of oOverflow
oAddr  out  ADDR_W  framebuffer write address
oData  out  3  framebuffer write colour
oWrEn  out  1  framebuffer write strobe; one write per high cycle
oEmpty  out  1  FIFO holds no entries
oFull  out  1  FIFO holds DEPTH entries
oCount  out  CNT_W  FIFO occupancy
oOverflow  out  1  sticky flag: a pixel was dropped because the FIFO was full
oRangeErr  out  1  one-cycle pulse: an out-of-range pixel was discarded

Behaviour:
- Reset (iResetn=0, asynchronous): FIFO pointers and count go to 0, stage-1 valid goes to 0, and oAddr=0, oData=0, oWrEn=0, oOverflow=0, oRangeErr=0, oCount=0, oFull=0, oEmpty=1. Any in-flight pixels are discarded.
- Stage 1 (address): on the edge where iPlot=1:
  - In range (iX < X_SCREEN_PIXELS and iY < Y_SCREEN_PIXELS): register addr = iY*X_SCREEN_PIXELS + iX, computed in ADDR_W bits (no truncation at defaults; (y<<7)+(y<<5)+x is acceptable), register the colour, and set s1_valid=1.
  - Out of range: s1_valid=0 and oRangeErr=1 for exactly one cycle.
  - iPlot=0: s1_valid=0.
- Stage 2 (FIFO push): when s1_valid=1, push {addr, colour} at the next edge.
  - Push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the entry is dropped and oOverflow is set to 1.
- oOverflow stays 1 until iClearOvf=1 or reset. If a clear and a new drop happen in the same cycle, the drop wins (oOverflow stays 1).
- Pop / output: on an edge where the FIFO is non-empty and iMemReady=1, the head entry is loaded into oAddr/oData, oWrEn=1 for the following cycle, and the head is popped.
  - Otherwise oWrEn=0 and oAddr/oData hold their last values.
  - All outputs are registered.
- Simultaneous push and pop: the count is unchanged and order is preserved. At empty, a push and a pop cannot happen in the same cycle; there is no bypass.
- Latency: with the FIFO empty and iMemReady held high, iPlot sampled at edge E0 gives oWrEn high in the cycle after E2 (3 cycles). Sustained throughput is 1 pixel per cycle.
- Ordering: writes leave strictly in iPlot acceptance order.
- oCount, oFull and oEmpty reflect FIFO contents only (not stage 1 and not the output register). All three update on the same edge as the push/pop.
- Pointers wrap modulo DEPTH. oCount ranges 0..DEPTH.
- iMemReady deasserting mid-burst stops pops at the next edge with no lost or duplicated entries.
- If iMemReady=1 while the FIFO is empty, no write occurs.

Test Plan:
1. Single pixel: reset, iMemReady=1, one-cycle iPlot with x=5, y=3, colour=6 → exactly one oWrEn pulse, 3 cycles after the sample edge, with oAddr=485 and oData=6. oEmpty=1 afterwards.
2. Bounds: (0,0) → oAddr=0. (159,119) → oAddr=19199. (160,0) and (0,120) → no write, one oRangeErr pulse each, oCount stays 0.
3. Backpressure and overflow: iMemReady=0, 17 consecutive iPlot cycles with x=0..16, y=0 → oFull=1 and oCount=16, 17th pixel dropped, oOverflow=1. Then set iMemReady=1 → 16 consecutive writes with oAddr=0..15 in order, then oEmpty=1, and oOverflow remains 1 until iClearOvf is pulsed.
4. Full with simultaneous push and pop: fill to 16, then iMemReady=1 together with a new iPlot stream → no drop, oCount holds at 16, and all addresses come out in order.
5. Ready toggling: 8 pixels with iMemReady alternating 1/0 per cycle → exactly 8 writes, on ready cycles only, in order, with no duplicates.
6. Reset mid-drain: 10 entries queued, assert iResetn=0 asynchronously mid-cycle → oWrEn=0 and oEmpty=1 immediately. After release, a pixel at (1,1) writes oAddr=161.
